// File: rtl/quiesce_monitor_if.sv
// Bus between the quiescence monitor and its observer: finish/clear controls,
// the core request lines, and the monitor's registered status outputs.
interface quiesce_monitor_if #(
    parameter int NUM_CORES = 32,
    parameter int CNT_W     = 16
);
    logic                 finish_req;
    logic                 clear;
    logic [NUM_CORES-1:0] core_req;
    logic                 test_finish;
    logic                 timeout;
    logic                 busy;
    logic [NUM_CORES-1:0] pending_mask;
    logic [CNT_W-1:0]     test_cnt;

    modport master (
        output finish_req, clear, core_req,
        input  test_finish, timeout, busy, pending_mask, test_cnt
    );

    modport slave (
        input  finish_req, clear, core_req,
        output test_finish, timeout, busy, pending_mask, test_cnt
    );
endinterface

// File: rtl/quiesce_monitor.sv
// End-of-test quiescence detector: after finish_req, waits for QUIET_CYCLES
// consecutive all-idle cycles, with a watchdog and a saturating test counter.
module quiesce_monitor #(
    parameter int NUM_CORES      = 32,
    parameter int QUIET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    quiesce_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_QUIET,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam int QC_W   = $clog2(QUIET_CYCLES + 1);
    localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit WD_EN  = (TIMEOUT_CYCLES > 0);

    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIM);

    state_t               state_q, state_d;
    logic [QC_W-1:0]      qcnt_q, qcnt_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 test_finish_q, test_finish_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic [NUM_CORES-1:0] pending_mask_q, pending_mask_d;
    logic [CNT_W-1:0]     test_cnt_q, test_cnt_d;
    logic                 idle;
    logic                 done_go;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idle = (bus.core_req == '0);

    always_comb begin
        state_d        = state_q;
        qcnt_d         = qcnt_q;
        wdog_d         = wdog_q;
        test_finish_d  = test_finish_q;
        timeout_d      = timeout_q;
        pending_mask_d = pending_mask_q;
        test_cnt_d     = test_cnt_q;
        done_go        = 1'b0;

        if (bus.clear) begin
            state_d       = ST_IDLE;
            qcnt_d        = '0;
            wdog_d        = '0;
            test_finish_d = 1'b0;
            timeout_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.finish_req) begin
                        state_d = ST_WAIT_IDLE;
                        wdog_d  = '0;
                        qcnt_d  = '0;
                    end
                end
                ST_WAIT_IDLE, ST_QUIET: begin
                    if (idle) begin
                        if (state_q == ST_WAIT_IDLE) begin
                            if (QUIET_CYCLES == 1) begin
                                done_go = 1'b1;
                            end else begin
                                state_d = ST_QUIET;
                                qcnt_d  = QC_W'(1);
                            end
                        end else if (qcnt_q == QC_LAST) begin
                            done_go = 1'b1;
                        end else begin
                            qcnt_d = qcnt_q + 1'b1;
                        end
                    end else begin
                        // Any busy core restarts the quiet window from scratch.
                        state_d = ST_WAIT_IDLE;
                        qcnt_d  = '0;
                    end
                    if (WD_EN) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                    // Reaching quiescence outranks a watchdog expiring on the same edge.
                    if (done_go) begin
                        state_d       = ST_DONE;
                        test_finish_d = 1'b1;
                        test_cnt_d    = sat_inc(test_cnt_q);
                    end else if (WD_EN && (wdog_q == WD_LAST)) begin
                        state_d        = ST_TIMEOUT;
                        timeout_d      = 1'b1;
                        pending_mask_d = bus.core_req;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_WAIT_IDLE) || (state_d == ST_QUIET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            qcnt_q         <= '0;
            wdog_q         <= '0;
            test_finish_q  <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            pending_mask_q <= '0;
            test_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            qcnt_q         <= qcnt_d;
            wdog_q         <= wdog_d;
            test_finish_q  <= test_finish_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            pending_mask_q <= pending_mask_d;
            test_cnt_q     <= test_cnt_d;
        end
    end

    assign bus.test_finish  = test_finish_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;
    assign bus.pending_mask = pending_mask_q;
    assign bus.test_cnt     = test_cnt_q;
endmodule

// File: tb/tb_quiesce_monitor.sv
// Directed bench for quiesce_monitor: finish, interrupted window, timeout,
// simultaneous events, counter saturation and asynchronous reset.
module tb_quiesce_monitor;
    localparam int NUM_CORES      = 32;
    localparam int QUIET_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    quiesce_monitor_if #(.NUM_CORES(NUM_CORES), .CNT_W(CNT_W)) bus ();

    quiesce_monitor #(
        .NUM_CORES     (NUM_CORES),
        .QUIET_CYCLES  (QUIET_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic tf, input logic to,
                                input logic bz, input logic [31:0] cnt);
        check({tag, ".test_finish"}, 32'(bus.test_finish), 32'(tf));
        check({tag, ".timeout"},     32'(bus.timeout),     32'(to));
        check({tag, ".busy"},        32'(bus.busy),        32'(bz));
        check({tag, ".test_cnt"},    32'(bus.test_cnt),    cnt);
    endtask

    task automatic pulse_finish();
        bus.finish_req = 1'b1;
        tick();
        bus.finish_req = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Finish with cores idle throughout: DONE lands QUIET_CYCLES edges after arming.
    task automatic quick_finish(input string tag, input logic [31:0] exp_cnt);
        bus.core_req = '0;
        pulse_finish();
        ticks(QUIET_CYCLES - 1);
        check_status({tag, ".pre"}, 1'b0, 1'b0, 1'b1, exp_cnt == 1 ? 32'd0 : (exp_cnt == 2 ? 32'd1 : 32'd3));
        tick();
        check_status(tag, 1'b1, 1'b0, 1'b0, exp_cnt);
        pulse_clear();
    endtask

    task automatic basic_finish(input string tag, input logic [31:0] exp_cnt);
        bus.core_req = 32'h0000_0005;
        pulse_finish();                 // edge 2
        ticks(7);                       // edges 3..9 busy
        bus.core_req = '0;
        ticks(3);                       // edges 10..12
        check_status({tag, ".e12"}, 1'b0, 1'b0, 1'b1, exp_cnt - 1);
        tick();                         // edge 13
        check_status({tag, ".e13"}, 1'b1, 1'b0, 1'b0, exp_cnt);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.finish_req = 1'b0;
        bus.clear      = 1'b0;
        bus.core_req   = '0;
        ticks(2);
        check_status("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        check("reset.pending_mask", bus.pending_mask, 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Basic finish; finish_req in DONE is ignored; clear keeps the count.
        basic_finish("basic", 32'd1);
        pulse_finish();
        check_status("done_ignores_finish", 1'b1, 1'b0, 1'b0, 32'd1);
        pulse_clear();
        check_status("clear_after_done", 1'b0, 1'b0, 1'b0, 32'd1);

        // Interrupted quiet window: finish at edge 1, pulse on bit 17 at edge 7.
        bus.core_req = 32'h0000_0001;
        pulse_finish();                 // edge 1
        ticks(3);                       // edges 2..4
        bus.core_req = '0;
        ticks(2);                       // edges 5,6
        bus.core_req = 32'h0002_0000;
        tick();                         // edge 7
        bus.core_req = '0;
        ticks(3);                       // edges 8..10
        check_status("interrupt.e10", 1'b0, 1'b0, 1'b1, 32'd1);
        tick();                         // edge 11
        check_status("interrupt.e11", 1'b1, 1'b0, 1'b0, 32'd2);
        pulse_clear();

        // Watchdog timeout with core 3 stuck busy.
        bus.core_req = 32'h0000_0008;
        pulse_finish();                 // edge 0
        ticks(15);                      // edges 1..15
        check_status("timeout.e15", 1'b0, 1'b0, 1'b1, 32'd2);
        tick();                         // edge 16
        check_status("timeout.e16", 1'b0, 1'b1, 1'b0, 32'd2);
        check("timeout.pending_mask", bus.pending_mask, 32'h0000_0008);
        bus.core_req = 32'h0000_00FF;
        pulse_finish();
        check_status("timeout.hold", 1'b0, 1'b1, 1'b0, 32'd2);
        check("timeout.pending_sticky", bus.pending_mask, 32'h0000_0008);
        bus.core_req = '0;
        pulse_clear();
        check_status("timeout.clear", 1'b0, 1'b0, 1'b0, 32'd2);
        check("timeout.pending_kept", bus.pending_mask, 32'h0000_0008);

        // DONE and TIMEOUT qualifying on edge 16: DONE must win.
        bus.core_req = 32'h0000_0001;
        pulse_finish();                 // edge 0
        ticks(12);                      // edges 1..12 busy
        bus.core_req = '0;
        ticks(3);                       // edges 13..15
        check_status("simul.e15", 1'b0, 1'b0, 1'b1, 32'd2);
        tick();                         // edge 16
        check_status("simul.e16", 1'b1, 1'b0, 1'b0, 32'd3);
        pulse_clear();

        // clear together with finish_req stays in IDLE.
        bus.clear      = 1'b1;
        bus.finish_req = 1'b1;
        tick();
        bus.clear      = 1'b0;
        bus.finish_req = 1'b0;
        check_status("clear_finish.e0", 1'b0, 1'b0, 1'b0, 32'd3);
        ticks(QUIET_CYCLES + 1);
        check_status("clear_finish.later", 1'b0, 1'b0, 1'b0, 32'd3);

        // Fourth and fifth successful finishes: counter saturates at 3.
        quick_finish("sat4", 32'd3);
        quick_finish("sat5", 32'd3);

        // Asynchronous reset in the middle of QUIET.
        bus.core_req = '0;
        pulse_finish();
        ticks(2);
        check_status("arst.pre", 1'b0, 1'b0, 1'b1, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("arst.during", 1'b0, 1'b0, 1'b0, 32'd0);
        check("arst.pending_mask", bus.pending_mask, 32'd0);
        #3;
        rst_n = 1'b1;
        ticks(2);
        basic_finish("after_arst", 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
